// File: rtl/playseq_condicionador_botoes.sv
// playseq_condicionador_botoes
// Input conditioner for the PlaySeq game: synchronizes and debounces the four
// game buttons and the jogar key, validates the button pattern and produces
// one-cycle strobes for the game control unit.
//
// Optional feature macro: PLAYSEQ_REJEITA_MULTIPLAS_EN
//   defined   -> non-one-hot stable patterns are rejected with erro_multiplas
//   undefined -> every stable pattern is accepted, lowest set bit wins
//
// Handshake: tem_jogada, erro_multiplas and jogar_pulso are single-cycle
// valid strobes with no ready; the consumer must sample them on the cycle
// they are high. jogada holds its value until the next tem_jogada.
module playseq_condicionador_botoes #(
   parameter int DEBOUNCE_CICLOS = 50000
) (
   input  logic       clock,
   input  logic       reset,
   input  logic [3:0] botoes_raw,
   input  logic       jogar_raw,
   output logic [3:0] jogada,
   output logic       tem_jogada,
   output logic       jogar_pulso,
   output logic       erro_multiplas,
   output logic [3:0] botoes_estaveis,
   output logic [3:0] db_estado
);

   localparam int CNT_W = $clog2(DEBOUNCE_CICLOS);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CICLOS - 1);

   typedef enum logic [1:0] {
      REPOUSO = 2'd0,
      FILTRA  = 2'd1,
      ACEITA  = 2'd2,
      ESPERA  = 2'd3
   } estado_t;

   estado_t          estado;
   logic [CNT_W-1:0] cnt;
   logic [3:0]       pad;

   logic [3:0]       bot_m;
   logic [3:0]       s_bot;
   logic             jog_m;
   logic             s_jog;

   logic [CNT_W-1:0] cnt_j;
   logic             jog_est;
   logic             jog_est_d;

`ifdef PLAYSEQ_REJEITA_MULTIPLAS_EN
   logic             pad_one_hot;
   // A pattern is one-hot when it is non-zero and clearing its lowest bit leaves nothing
   assign pad_one_hot = (pad != 4'd0) && ((pad & (pad - 4'd1)) == 4'd0);
`else
   logic [3:0]       pad_low;
   // Isolate the lowest set bit (two's complement trick) as the priority winner
   assign pad_low = pad & (~pad + 4'd1);
`endif

   // State code for the seven-segment debug display
   assign db_estado = {2'b00, estado};

   // Two-stage synchronizer on all five raw inputs
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         bot_m <= 4'd0;
         s_bot <= 4'd0;
         jog_m <= 1'b0;
         s_jog <= 1'b0;
      end else begin
         bot_m <= botoes_raw;
         s_bot <= bot_m;
         jog_m <= jogar_raw;
         s_jog <= jog_m;
      end
   end

   // Button FSM: filter a press, accept or reject it once, then wait for a stable release
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         estado          <= REPOUSO;
         cnt             <= '0;
         pad             <= 4'd0;
         jogada          <= 4'd0;
         tem_jogada      <= 1'b0;
         erro_multiplas  <= 1'b0;
         botoes_estaveis <= 4'd0;
      end else begin
         tem_jogada     <= 1'b0;
         erro_multiplas <= 1'b0;
         case (estado)
            REPOUSO: begin
               if (s_bot != 4'd0) begin
                  pad    <= s_bot;
                  cnt    <= '0;
                  estado <= FILTRA;
               end
            end
            FILTRA: begin
               if (s_bot == 4'd0) begin
                  estado <= REPOUSO;
               end else if (s_bot != pad) begin
                  // pattern moved while filtering: restart on the new pattern
                  pad <= s_bot;
                  cnt <= '0;
               end else if (cnt == CNT_MAX) begin
                  estado          <= ACEITA;
                  botoes_estaveis <= pad;
`ifdef PLAYSEQ_REJEITA_MULTIPLAS_EN
                  if (pad_one_hot) begin
                     jogada     <= pad;
                     tem_jogada <= 1'b1;
                  end else begin
                     erro_multiplas <= 1'b1;
                  end
`else
                  jogada     <= pad_low;
                  tem_jogada <= 1'b1;
`endif
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            ACEITA: begin
               // strobes were registered on entry; only arm the release filter here
               cnt    <= '0;
               estado <= ESPERA;
            end
            ESPERA: begin
               if (s_bot != 4'd0) begin
                  cnt <= '0;
               end else if (cnt == CNT_MAX) begin
                  estado          <= REPOUSO;
                  botoes_estaveis <= 4'd0;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            default: estado <= REPOUSO;
         endcase
      end
   end

   // Jogar debouncer: toggle the stable level after a full run of disagreeing samples
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt_j   <= '0;
         jog_est <= 1'b0;
      end else if (s_jog == jog_est) begin
         cnt_j <= '0;
      end else if (cnt_j == CNT_MAX) begin
         jog_est <= ~jog_est;
         cnt_j   <= '0;
      end else begin
         cnt_j <= cnt_j + CNT_W'(1);
      end
   end

   // Rising-edge detector on the debounced jogar level; the extra stage aligns its latency with tem_jogada
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         jog_est_d   <= 1'b0;
         jogar_pulso <= 1'b0;
      end else begin
         jog_est_d   <= jog_est;
         jogar_pulso <= jog_est & ~jog_est_d;
      end
   end

endmodule

// File: tb/tb_playseq_condicionador_botoes.sv
// Bench for playseq_condicionador_botoes with DEBOUNCE_CICLOS = 4.
// Button strobes are predicted as {kind, jogada, cycle} entries; jogar strobes
// as cycle entries. kind is {erro_multiplas, tem_jogada}.
module tb_playseq_condicionador_botoes;

   localparam int D = 4;
   localparam int LAT = D + 3;

   logic       clock;
   logic       reset;
   logic [3:0] botoes_raw;
   logic       jogar_raw;
   logic [3:0] jogada;
   logic       tem_jogada;
   logic       jogar_pulso;
   logic       erro_multiplas;
   logic [3:0] botoes_estaveis;
   logic [3:0] db_estado;

   logic [21:0] exp_q[$];
   logic [15:0] jog_q[$];

   int n_cmp;
   int n_fail;
   int cyc;

   playseq_condicionador_botoes #(.DEBOUNCE_CICLOS(D)) dut (
      .clock           (clock),
      .reset           (reset),
      .botoes_raw      (botoes_raw),
      .jogar_raw       (jogar_raw),
      .jogada          (jogada),
      .tem_jogada      (tem_jogada),
      .jogar_pulso     (jogar_pulso),
      .erro_multiplas  (erro_multiplas),
      .botoes_estaveis (botoes_estaveis),
      .db_estado       (db_estado)
   );

   // clock and cycle counter
   initial clock = 1'b0;
   always #5 clock = ~clock;
   initial cyc = 0;
   always @(posedge clock) cyc = cyc + 1;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
      end
   endtask

   task automatic chk_all_zero(input string nm);
      chk({nm, "_jogada"}, 32'(jogada), 32'd0);
      chk({nm, "_tem_jogada"}, 32'(tem_jogada), 32'd0);
      chk({nm, "_jogar_pulso"}, 32'(jogar_pulso), 32'd0);
      chk({nm, "_erro"}, 32'(erro_multiplas), 32'd0);
      chk({nm, "_estaveis"}, 32'(botoes_estaveis), 32'd0);
      chk({nm, "_estado"}, 32'(db_estado), 32'd0);
   endtask

   // driver helpers: called at a negedge, the next posedge is sampling edge 1
   task automatic expect_bot(input logic [1:0] kind, input logic [3:0] j);
      exp_q.push_back({kind, j, 16'(cyc + LAT)});
   endtask

   task automatic expect_jog();
      jog_q.push_back(16'(cyc + LAT));
   endtask

   task automatic wait_cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   // monitor: every strobe pops one prediction and must match kind, value and cycle
   always @(negedge clock) begin
      logic [21:0] e;
      logic [15:0] ej;
      if (tem_jogada || erro_multiplas) begin
         if (exp_q.size() == 0) begin
            chk("unexpected_bot_strobe", {erro_multiplas, tem_jogada, jogada, 16'(cyc)}, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("bot_strobe", 32'({erro_multiplas, tem_jogada, jogada, 16'(cyc)}), 32'(e));
         end
      end
      if (jogar_pulso) begin
         if (jog_q.size() == 0) begin
            chk("unexpected_jogar_pulso", 32'(cyc), 32'hFFFF_FFFF);
         end else begin
            ej = jog_q.pop_front();
            chk("jogar_pulso", 32'(cyc), 32'(ej));
         end
      end
   end

   // directed stimulus
   initial begin
      n_cmp = 0;
      n_fail = 0;
      reset = 1'b0;
      botoes_raw = 4'd0;
      jogar_raw = 1'b0;
      wait_cyc(3);
      chk_all_zero("reset_init");
      reset = 1'b1;
      wait_cyc(2);

      // single clean press of 0100
      botoes_raw = 4'b0100;
      expect_bot(2'b01, 4'b0100);
      wait_cyc(10);
      chk("hold_estado_espera", 32'(db_estado), 32'd3);
      chk("hold_estaveis", 32'(botoes_estaveis), 32'b0100);
      wait_cyc(10);
      botoes_raw = 4'd0;
      wait_cyc(10);
      chk("release_estado", 32'(db_estado), 32'd0);
      chk("release_estaveis", 32'(botoes_estaveis), 32'd0);
      chk("release_jogada_held", 32'(jogada), 32'b0100);

      // bouncing 0010, only the final stable press may count
      for (int i = 0; i < 2; i++) begin
         botoes_raw = 4'b0010;
         wait_cyc(2);
         botoes_raw = 4'd0;
         wait_cyc(2);
      end
      botoes_raw = 4'b0010;
      expect_bot(2'b01, 4'b0010);
      wait_cyc(15);
      botoes_raw = 4'd0;
      wait_cyc(10);

      // two buttons at once
      botoes_raw = 4'b0011;
`ifdef PLAYSEQ_REJEITA_MULTIPLAS_EN
      expect_bot(2'b10, 4'b0010);
`else
      expect_bot(2'b01, 4'b0001);
`endif
      wait_cyc(10);
      chk("multi_estaveis", 32'(botoes_estaveis), 32'b0011);
      wait_cyc(5);
      botoes_raw = 4'd0;
      wait_cyc(10);

      // short release must not re-arm; a long release must
      botoes_raw = 4'b1000;
      expect_bot(2'b01, 4'b1000);
      wait_cyc(12);
      botoes_raw = 4'd0;
      wait_cyc(2);
      botoes_raw = 4'b1000;
      wait_cyc(12);
      chk("short_release_estado", 32'(db_estado), 32'd3);
      botoes_raw = 4'd0;
      wait_cyc(10);
      botoes_raw = 4'b1000;
      expect_bot(2'b01, 4'b1000);
      wait_cyc(12);
      botoes_raw = 4'd0;
      wait_cyc(10);

      // jogar alone, then release (no pulse on the falling side)
      jogar_raw = 1'b1;
      expect_jog();
      wait_cyc(10);
      jogar_raw = 1'b0;
      wait_cyc(12);

      // jogar and a button together: both strobes in the same cycle
      jogar_raw = 1'b1;
      botoes_raw = 4'b0001;
      expect_jog();
      expect_bot(2'b01, 4'b0001);
      wait_cyc(12);
      jogar_raw = 1'b0;
      botoes_raw = 4'd0;
      wait_cyc(12);

      // reset mid-press, button still held afterwards counts as a new press
      botoes_raw = 4'b0100;
      expect_bot(2'b01, 4'b0100);
      wait_cyc(9);
      chk("pre_reset_estaveis", 32'(botoes_estaveis), 32'b0100);
      reset = 1'b0;
      #1;
      chk_all_zero("reset_async");
      wait_cyc(3);
      reset = 1'b1;
      expect_bot(2'b01, 4'b0100);
      wait_cyc(12);
      botoes_raw = 4'd0;
      wait_cyc(15);

      chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
      chk("jog_q_drained", 32'(jog_q.size()), 32'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule

// File: doc/playseq_condicionador_botoes.md
# playseq_condicionador_botoes

Input conditioner for the PlaySeq game, directly upstream of the game top level. It synchronizes and debounces the four raw game buttons and the `jogar` key, and validates that exactly one button was pressed. It emits a held 4-bit move code plus a one-cycle `tem_jogada` strobe, and a one-cycle `jogar` strobe, both consumed by the game's data path and control unit.

## Interface
Parameters:
- `DEBOUNCE_CICLOS`, default 50000: number of consecutive stable cycles required to accept a level change (1 ms at 50 MHz). Must be ≥ 2. Counter width is `$clog2(DEBOUNCE_CICLOS)`.

Ports (one clock; reset is asynchronous and active-low):
- `clock`  in  1  system clock, all state updates on rising edge
- `reset`  in  1  asynchronous active-low reset (0 = reset asserted)
- `botoes_raw`  in  4  raw button levels, 1 = pressed, asynchronous to `clock`
- `jogar_raw`  in  1  raw start key, 1 = pressed, asynchronous
- `jogada`  out  4  last accepted move, one-hot, held until next acceptance
- `tem_jogada`  out  1  one-cycle strobe: `jogada` was just updated
- `jogar_pulso`  out  1  one-cycle strobe on debounced rising edge of `jogar_raw`
- `erro_multiplas`  out  1  one-cycle strobe: a stable non-one-hot pattern was rejected
- `botoes_estaveis`  out  4  debounced button pattern (debug)
- `db_estado`  out  4  FSM state code for the `hexa7seg` display

## Operation
- Synchronizer: two flip-flop stages on each of the 5 raw inputs. All logic below uses the synchronized values `s_bot` and `s_jog`.
- Button FSM, one counter `cnt`, and captured pattern `pad`:
  - REPOUSO (code 0): if `s_bot` ≠ 0, then `pad` ← `s_bot`, `cnt` ← 0, and go to FILTRA.
  - FILTRA (1):
    - If `s_bot` = 0, go to REPOUSO.
    - Else if `s_bot` ≠ `pad`, then `pad` ← `s_bot` and `cnt` ← 0.
    - Else if `cnt` = `DEBOUNCE_CICLOS`−1, go to ACEITA and set `botoes_estaveis` ← `pad`.
    - Otherwise `cnt`++.
  - ACEITA (2), lasting one cycle:
    - If `pad` is one-hot: `tem_jogada` = 1, with `jogada` loaded on entry.
    - Otherwise: `erro_multiplas` = 1, and `jogada` is unchanged.
    - Then go to ESPERA.
  - ESPERA (3): wait for release.
    - If `s_bot` ≠ 0, then `cnt` ← 0.
    - Else if `cnt` = `DEBOUNCE_CICLOS`−1, go to REPOUSO and set `botoes_estaveis` ← 0.
    - Otherwise `cnt`++.
    - No new move is accepted until the release has been stable.
- Jogar path: an independent counter and a stable bit `jog_est`.
  - When `s_jog` ≠ `jog_est` for `DEBOUNCE_CICLOS` consecutive cycles, `jog_est` toggles.
  - `jogar_pulso` = 1 for exactly one cycle on the 0→1 toggle of `jog_est`.
  - The jogar path is independent of the button FSM, so both strobes may occur in the same cycle.
- All outputs are registered.
- Reset values:
  - `jogada` = 0000, `tem_jogada` = 0, `jogar_pulso` = 0, `erro_multiplas` = 0
  - `botoes_estaveis` = 0000, `db_estado` = 0
  - State = REPOUSO, both counters = 0, `jog_est` = 0, synchronizers = 0
- If reset is asserted mid-press, the block returns to REPOUSO. A button still held when reset is released is debounced as a new press.

## Timing
- Number rising edges from 1, where edge 1 is the first edge at which the raw press is sampled, and the press is held stable.
  - Synchronizer output is valid after edge 2.
  - The FSM enters FILTRA at edge 3 and enters ACEITA at edge `DEBOUNCE_CICLOS`+3.
  - `tem_jogada` is high between edges `DEBOUNCE_CICLOS`+3 and `DEBOUNCE_CICLOS`+4.
  - `jogada` is valid from edge `DEBOUNCE_CICLOS`+3 onward.
- Glitch handling: any glitch shorter than `DEBOUNCE_CICLOS` cycles, in either FILTRA or ESPERA, restarts the count. It never produces a strobe.
- `jogar_pulso` has the same latency, measured from the `jogar_raw` rise: it is high between edges `DEBOUNCE_CICLOS`+3 and `DEBOUNCE_CICLOS`+4.
- `tem_jogada`, `erro_multiplas`: at most one of the two per press; never high for two consecutive cycles.

## Configuration
- `PLAYSEQ_REJEITA_MULTIPLAS_EN`:
  - Defined: ACEITA behaves as above. Non-one-hot stable patterns are rejected with an `erro_multiplas` strobe.
  - Undefined: ACEITA always accepts. `jogada` is loaded with the lowest-index set bit of `pad` (priority encode), and `tem_jogada` = 1. `erro_multiplas` is tied to 0.

## Test plan
Sim with `DEBOUNCE_CICLOS` = 4.
- Reset with `reset` = 0 mid-run → all outputs 0 and `db_estado` = 0 in the same cycle, without waiting for a clock edge.
- Hold `botoes_raw` = 0100 for 20 cycles → one `tem_jogada` pulse exactly 7 cycles after the first sampling edge; `jogada` = 0100 and held after release.
- `botoes_raw` = 0010 with 2-cycle bounces (1,0,1,0), then stable → a single `tem_jogada`, counted from the last bounce; no strobe during the bounces.
- Stable 0011:
  - With the macro defined → `erro_multiplas` pulse, no `tem_jogada`, `jogada` keeps its previous value.
  - Without the macro → `tem_jogada`, `jogada` = 0001.
- Press 1000, release for 2 cycles, press 1000 again → only one `tem_jogada` (ESPERA not satisfied); after a 10-cycle release plus a new press → a second strobe.
- Raise `jogar_raw` for 10 cycles → `jogar_pulso` high for exactly one cycle, 7 cycles after the first sampling edge; lowering it → no pulse.
